vga_scan_gen: RTL and testbench

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

---
 rtl/vga_scan_gen_if.sv | 14 +
 rtl/vga_scan_gen.sv | 175 +++++++++++++++++
 tb/tb_vga_scan_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_gen_if.sv
// Renderer link: the scan generator publishes the coordinate it is scanning and
// receives the renderer's colour for that coordinate PIPE_LAT clocks later.
interface vga_scan_gen_if #(
  parameter int PIX_WIDTH = 12
);
  logic [PIX_WIDTH-1:0] pix_x_o;
  logic [PIX_WIDTH-1:0] pix_y_o;
  logic [23:0]          vga_data_i;
  logic                 vga_data_en_i;

  // master = scan generator, slave = pixel renderer
  modport master (output pix_x_o, pix_y_o, input  vga_data_i, vga_data_en_i);
  modport slave  (input  pix_x_o, pix_y_o, output vga_data_i, vga_data_en_i);
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: free-running h/v counters, sync/active decode
// delayed to match the renderer pipeline, and a registered pin stage.
module vga_scan_gen #(
  parameter int          PIX_WIDTH = 12,
  parameter int          H_ACTIVE  = 1024,
  parameter int          H_FP      = 24,
  parameter int          H_SYNC    = 136,
  parameter int          H_BP      = 160,
  parameter int          V_ACTIVE  = 768,
  parameter int          V_FP      = 3,
  parameter int          V_SYNC    = 6,
  parameter int          V_BP      = 29,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int          PIPE_LAT  = 1,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vga_scan_gen_if.master rnd_if,
  output logic [23:0]    vga_rgb_o,
  output logic           vga_hs_o,
  output logic           vga_vs_o,
  output logic           vga_de_o,
  output logic           frame_start_o,
  output logic           vblank_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [PIX_WIDTH-1:0] H_LAST = PIX_WIDTH'(H_TOTAL - 1);
  localparam logic [PIX_WIDTH-1:0] V_LAST = PIX_WIDTH'(V_TOTAL - 1);
  localparam logic [PIX_WIDTH-1:0] H_ACT  = PIX_WIDTH'(H_ACTIVE);
  localparam logic [PIX_WIDTH-1:0] V_ACT  = PIX_WIDTH'(V_ACTIVE);
  localparam logic [PIX_WIDTH-1:0] HS_BEG = PIX_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [PIX_WIDTH-1:0] HS_END = PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [PIX_WIDTH-1:0] VS_BEG = PIX_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [PIX_WIDTH-1:0] VS_END = PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL >= (1 << PIX_WIDTH)) begin : g_chk_h_total
      $error("vga_scan_gen: H_TOTAL does not fit in PIX_WIDTH bits");
    end
    if (V_TOTAL >= (1 << PIX_WIDTH)) begin : g_chk_v_total
      $error("vga_scan_gen: V_TOTAL does not fit in PIX_WIDTH bits");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_chk_pipe_lat
      $error("vga_scan_gen: PIPE_LAT must be in 0..7");
    end
  endgenerate

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } raw_t;

  logic [PIX_WIDTH-1:0] h_cnt_q, h_cnt_d;
  logic [PIX_WIDTH-1:0] v_cnt_q, v_cnt_d;
  logic                 h_wrap;
  logic                 v_wrap;
  raw_t                 raw;
  raw_t                 dly;

  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign rnd_if.pix_x_o = h_cnt_q;
  assign rnd_if.pix_y_o = v_cnt_q;
  assign vblank_o       = (v_cnt_q >= V_ACT);

  // ---------------------------------------------------------------------------
  // Raw timing decode, delayed to line up with the renderer's answer
  // ---------------------------------------------------------------------------
  always_comb begin
    raw.act = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw.hs  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    raw.vs  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  end

  generate
    if (PIPE_LAT == 0) begin : g_direct
      assign dly = raw;
    end else begin : g_pipe
      raw_t pipe_q [PIPE_LAT];

      // NOTE: the delay stages are cleared on reset (unlike a data memory)
      // because right after reset they must read as "blanked, sync idle",
      // not as whatever the flops powered up with.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= raw;
          for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign dly = pipe_q[PIPE_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pin register: one more clock, so counter-to-pin latency is PIPE_LAT+1
  // ---------------------------------------------------------------------------
  always_comb begin
    rgb_d = 24'h0;
    if (dly.act) begin
      rgb_d = rnd_if.vga_data_en_i ? rnd_if.vga_data_i : BG_COLOR;
    end
    de_d = dly.act;
    hs_d = dly.hs ~^ HS_POL;
    vs_d = dly.vs ~^ VS_POL;
    fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rgb_q <= 24'h0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign vga_rgb_o     = rgb_q;
  assign vga_de_o      = de_q;
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a shrunken 25x16 raster: a PIPE_LAT=1 active-low
// instance and a PIPE_LAT=2 active-high instance, both against a cycle-count model.
module tb_vga_scan_gen;

  localparam int PW    = 12;
  localparam int HA    = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA    = 10, VFP = 1, VSW = 2, VBP = 3;
  localparam int HT    = HA + HFP + HSW + HBP;  // 25
  localparam int VT    = VA + VFP + VSW + VBP;  // 16
  localparam int FRAME = HT * VT;               // 400
  localparam logic [23:0] BG1 = 24'h00A5C3;
  localparam logic [23:0] BG2 = 24'h000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_scan_gen_if #(.PIX_WIDTH(PW)) if1 ();
  vga_scan_gen_if #(.PIX_WIDTH(PW)) if2 ();

  logic [23:0] rgb1, rgb2;
  logic        hs1, vs1, de1, fs1, vb1;
  logic        hs2, vs2, de2, fs2, vb2;

  vga_scan_gen #(
    .PIX_WIDTH(PW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(1), .BG_COLOR(BG1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst_n), .rnd_if(if1),
    .vga_rgb_o(rgb1), .vga_hs_o(hs1), .vga_vs_o(vs1), .vga_de_o(de1),
    .frame_start_o(fs1), .vblank_o(vb1)
  );

  vga_scan_gen #(
    .PIX_WIDTH(PW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(2), .BG_COLOR(BG2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst_n), .rnd_if(if2),
    .vga_rgb_o(rgb2), .vga_hs_o(hs2), .vga_vs_o(vs2), .vga_de_o(de2),
    .frame_start_o(fs2), .vblank_o(vb2)
  );

  // Observation word: {x, y, rgb, hs, vs, de, frame_start, vblank}
  logic [52:0] obs1, obs2;
  assign obs1 = {if1.pix_x_o, if1.pix_y_o, rgb1, hs1, vs1, de1, fs1, vb1};
  assign obs2 = {if2.pix_x_o, if2.pix_y_o, rgb2, hs2, vs2, de2, fs2, vb2};

  localparam logic [52:0] RST1 = {12'd0, 12'd0, 24'h0, 1'b1, 1'b1, 3'b000};
  localparam logic [52:0] RST2 = {12'd0, 12'd0, 24'h0, 1'b0, 1'b0, 3'b000};

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;  // clock edges since reset release

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Expected outputs k clocks after release, from the raster rules alone:
  // position is k mod frame; pins show the position from lat+1 clocks ago.
  function automatic logic [52:0] model(input int k, input int lat, input bit hpol,
                                        input bit vpol, input logic [23:0] bg,
                                        input logic en, input logic [23:0] d);
    int idx, h, v, m, mh, mv;
    bit act, hsy, vsy, fs;
    logic [23:0] rgb;
    idx = k % FRAME;
    h   = idx % HT;
    v   = idx / HT;
    act = 1'b0; hsy = 1'b0; vsy = 1'b0;
    mh  = 0; mv = 0;
    m   = k - lat - 1;
    if (m >= 0) begin
      mh  = (m % FRAME) % HT;
      mv  = (m % FRAME) / HT;
      act = (mh < HA) && (mv < VA);
      hsy = (mh >= HA + HFP) && (mh < HA + HFP + HSW);
      vsy = (mv >= VA + VFP) && (mv < VA + VFP + VSW);
    end
    fs  = (k >= 1) && (((k - 1) % FRAME) == 0);
    rgb = act ? (en ? d : bg) : 24'h0;
    return {PW'(h), PW'(v), rgb, hsy ? hpol : ~hpol, vsy ? vpol : ~vpol, act, fs, v >= VA};
  endfunction

  task automatic model_check();
    check($sformatf("dut1 cyc %0d", n), 64'(obs1),
          64'(model(n, 1, 1'b0, 1'b0, BG1, if1.vga_data_en_i, if1.vga_data_i)));
    check($sformatf("dut2 cyc %0d", n), 64'(obs2),
          64'(model(n, 2, 1'b1, 1'b1, BG2, if2.vga_data_en_i, if2.vga_data_i)));
  endtask

  task automatic reset_check(input string tag);
    check($sformatf("%s dut1", tag), 64'(obs1), 64'(RST1));
    check($sformatf("%s dut2", tag), 64'(obs2), 64'(RST2));
  endtask

  task automatic advance();
    @(posedge clk);
    n++;
    #1;
  endtask

  // Renderer for dut2: answers 24'h123456 only for pixel (5,7), two clocks late.
  task automatic drive_renderer2();
    int m;
    m = n - 2;
    if (m >= 0 && (m % FRAME) == 7 * HT + 5) begin
      if2.vga_data_en_i = 1'b1;
      if2.vga_data_i    = 24'h123456;
    end else begin
      if2.vga_data_en_i = 1'b0;
      if2.vga_data_i    = 24'hABCDEF;
    end
  endtask

  task automatic drive_random();
    if1.vga_data_en_i = 1'($urandom_range(0, 1));
    if1.vga_data_i    = 24'($urandom);
    if2.vga_data_en_i = 1'($urandom_range(0, 1));
    if2.vga_data_i    = 24'($urandom);
  endtask

  typedef struct {
    int          cyc;
    logic        en;
    logic [23:0] data;
    logic [11:0] x, y;
    logic [23:0] rgb;
    logic        hs, vs, de, fs, vb;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  initial begin
    int e;
    int hits;
    int hit_n;
    logic [52:0] want;

    // cyc, en, data driven in the clocks leading up to cyc, then expected dut1 pins
    tbl[0]  = '{0,   1'b0, 24'h000000, 12'd0,  12'd0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1,   1'b0, 24'h000000, 12'd1,  12'd0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{2,   1'b0, 24'h000000, 12'd2,  12'd0,  BG1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3,   1'b1, 24'h112233, 12'd3,  12'd0,  24'h112233, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{17,  1'b1, 24'h445566, 12'd17, 12'd0,  24'h445566, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{19,  1'b1, 24'hFFFFFF, 12'd19, 12'd0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{20,  1'b1, 24'hFFFFFF, 12'd20, 12'd0,  24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{22,  1'b0, 24'h000000, 12'd22, 12'd0,  24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{23,  1'b0, 24'h000000, 12'd23, 12'd0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{25,  1'b0, 24'h000000, 12'd0,  12'd1,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{27,  1'b0, 24'h000000, 12'd2,  12'd1,  BG1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{249, 1'b0, 24'h000000, 12'd24, 12'd9,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{250, 1'b0, 24'h000000, 12'd0,  12'd10, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{276, 1'b0, 24'h000000, 12'd1,  12'd11, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{277, 1'b0, 24'h000000, 12'd2,  12'd11, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{326, 1'b0, 24'h000000, 12'd1,  12'd13, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{327, 1'b0, 24'h000000, 12'd2,  12'd13, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{399, 1'b0, 24'h000000, 12'd24, 12'd15, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{400, 1'b0, 24'h000000, 12'd0,  12'd0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{401, 1'b0, 24'h000000, 12'd1,  12'd0,  24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    if1.vga_data_en_i = 1'b0;
    if1.vga_data_i    = 24'h0;
    if2.vga_data_en_i = 1'b0;
    if2.vga_data_i    = 24'h0;

    // Power-on reset held for three clocks
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_check("in reset");

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = 0;

    // First frame: directed table on dut1, single-pixel renderer on dut2
    e     = 0;
    hits  = 0;
    hit_n = -1;
    forever begin
      model_check();
      if (e < NV && tbl[e].cyc == n) begin
        want = {tbl[e].x, tbl[e].y, tbl[e].rgb, tbl[e].hs, tbl[e].vs,
                tbl[e].de, tbl[e].fs, tbl[e].vb};
        check($sformatf("tbl[%0d] cyc %0d", e, n), 64'(obs1), 64'(want));
        e++;
      end
      if (rgb2 == 24'h123456 && de2) begin
        hits++;
        hit_n = n;
      end
      if (n == 401) break;
      if1.vga_data_en_i = (e < NV) ? tbl[e].en   : 1'b0;
      if1.vga_data_i    = (e < NV) ? tbl[e].data : 24'h0;
      drive_renderer2();
      advance();
    end
    check("table entries reached", 64'(e), 64'(NV));
    check("pixel (5,7) hit count", 64'(hits), 64'(1));
    check("pixel (5,7) hit cycle", 64'(hit_n), 64'(7 * HT + 5 + 3));

    // Random renderer data across several frames
    while (n < 1300) begin
      drive_random();
      advance();
      model_check();
    end

    // Reach x=7 mid-line, then drop reset between clock edges
    while ((n % HT) != 7) begin
      drive_random();
      advance();
      model_check();
    end
    #3;
    rst_n = 1'b0;
    #1;
    reset_check("async reset mid-line");
    repeat (2) @(posedge clk);
    #1;
    reset_check("held in reset");

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = 0;
    model_check();
    repeat (450) begin
      drive_random();
      advance();
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
